// File: rtl/mrv1_dec_pkg.sv
// Shared decode types: micro-op classes, thread-control ops, RV32I/custom-0
// opcodes and the decoded record carried through the output buffer.
package mrv1_dec_pkg;

    typedef enum logic [3:0] {
        UOP_ALU, UOP_ALUI, UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR,
        UOP_BRANCH, UOP_LOAD, UOP_STORE, UOP_FENCE, UOP_SYSTEM, UOP_THCTL
    } uop_e;

    typedef enum logic [1:0] {TH_NONE, TH_TSPAWN, TH_BARRIER} thctl_e;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;

    typedef struct packed {
        uop_e        uop;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        rs1_re;
        logic        rs2_re;
        logic [31:0] imm;
        thctl_e      thctl;
        logic        illegal;
    } dec_rec_t;

endpackage

// File: rtl/mrv1_idecode_if.sv
// Fetch->decode and decode->issue handshakes bundled together; slave is the
// decode stage, master is whatever drives fetch beats and consumes micro-ops.
interface mrv1_idecode_if #(
    parameter int PC_WIDTH_P    = 32,
    parameter int NUM_THREADS_P = 8,
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
);
    logic                    ifetch_insn_vld_i;
    logic                    ifetch_insn_rdy_o;
    logic [31:0]             ifetch_insn_data_i;
    logic [PC_WIDTH_P-1:0]   ifetch_insn_pc_i;
    logic [TID_WIDTH_LP-1:0] ifetch_insn_tid_i;

    logic                    dec_vld_o;
    logic                    dec_rdy_i;
    logic [PC_WIDTH_P-1:0]   dec_pc_o;
    logic [TID_WIDTH_LP-1:0] dec_tid_o;
    logic [3:0]              dec_uop_o;
    logic [2:0]              dec_funct3_o;
    logic                    dec_alt_o;
    logic [4:0]              dec_rd_o, dec_rs1_o, dec_rs2_o;
    logic                    dec_rd_we_o, dec_rs1_re_o, dec_rs2_re_o;
    logic [31:0]             dec_imm_o;
    logic [1:0]              dec_thctl_o;
    logic                    dec_illegal_o;

    modport slave (
        input  ifetch_insn_vld_i, ifetch_insn_data_i, ifetch_insn_pc_i, ifetch_insn_tid_i,
        output ifetch_insn_rdy_o,
        input  dec_rdy_i,
        output dec_vld_o, dec_pc_o, dec_tid_o, dec_uop_o, dec_funct3_o, dec_alt_o,
               dec_rd_o, dec_rs1_o, dec_rs2_o, dec_rd_we_o, dec_rs1_re_o, dec_rs2_re_o,
               dec_imm_o, dec_thctl_o, dec_illegal_o
    );

    modport master (
        output ifetch_insn_vld_i, ifetch_insn_data_i, ifetch_insn_pc_i, ifetch_insn_tid_i,
        input  ifetch_insn_rdy_o,
        output dec_rdy_i,
        input  dec_vld_o, dec_pc_o, dec_tid_o, dec_uop_o, dec_funct3_o, dec_alt_o,
               dec_rd_o, dec_rs1_o, dec_rs2_o, dec_rd_we_o, dec_rs1_re_o, dec_rs2_re_o,
               dec_imm_o, dec_thctl_o, dec_illegal_o
    );
endinterface

// File: rtl/mrv1_dec_logic.sv
// Combinational RV32I + custom-0 thread-control decoder: raw instruction to
// decoded record. Illegal encodings collapse to an inert ALUI with no side effects.
module mrv1_dec_logic
    import mrv1_dec_pkg::*;
(
    input  logic [31:0] insn_i,
    output dec_rec_t    rec_o
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        we, bad;

    assign opc   = insn_i[6:0];
    assign f3    = insn_i[14:12];
    assign f7    = insn_i[31:25];
    assign imm_i = {{20{insn_i[31]}}, insn_i[31:20]};
    assign imm_s = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
    assign imm_b = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
    assign imm_u = {insn_i[31:12], 12'b0};
    assign imm_j = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

    always_comb begin
        rec_o        = '0;
        rec_o.uop    = UOP_ALUI;
        rec_o.thctl  = TH_NONE;
        rec_o.funct3 = f3;
        rec_o.rd     = insn_i[11:7];
        rec_o.rs1    = insn_i[19:15];
        rec_o.rs2    = insn_i[24:20];
        we           = 1'b0;
        bad          = 1'b0;
        // every legal opcode ends in 2'b11, so a compressed encoding lands in default
        case (opc)
            OPC_OP: begin
                rec_o.uop = UOP_ALU; rec_o.alt = f7[5];
                we = 1'b1; rec_o.rs1_re = 1'b1; rec_o.rs2_re = 1'b1;
                bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OPC_OP_IMM: begin
                rec_o.uop = UOP_ALUI; rec_o.imm = imm_i; we = 1'b1; rec_o.rs1_re = 1'b1;
                rec_o.alt = (f3 == 3'd5) && f7[5];
                bad = (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            OPC_LUI:   begin rec_o.uop = UOP_LUI;   rec_o.imm = imm_u; we = 1'b1; end
            OPC_AUIPC: begin rec_o.uop = UOP_AUIPC; rec_o.imm = imm_u; we = 1'b1; end
            OPC_JAL:   begin rec_o.uop = UOP_JAL;   rec_o.imm = imm_j; we = 1'b1; end
            OPC_JALR: begin
                rec_o.uop = UOP_JALR; rec_o.imm = imm_i; we = 1'b1; rec_o.rs1_re = 1'b1;
                bad = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                rec_o.uop = UOP_BRANCH; rec_o.imm = imm_b;
                rec_o.rs1_re = 1'b1; rec_o.rs2_re = 1'b1;
                bad = (f3 == 3'd2 || f3 == 3'd3);
            end
            OPC_LOAD: begin
                rec_o.uop = UOP_LOAD; rec_o.imm = imm_i; we = 1'b1; rec_o.rs1_re = 1'b1;
                bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            end
            OPC_STORE: begin
                rec_o.uop = UOP_STORE; rec_o.imm = imm_s;
                rec_o.rs1_re = 1'b1; rec_o.rs2_re = 1'b1;
                bad = (f3 > 3'd2);
            end
            OPC_MISC_MEM: begin rec_o.uop = UOP_FENCE; rec_o.imm = imm_i; end
            OPC_SYSTEM: begin
                // CSR forms write rd; register-source CSR forms also read rs1
                rec_o.uop = UOP_SYSTEM; rec_o.imm = imm_i;
                we = (f3 != 3'd0);
                rec_o.rs1_re = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
            end
            OPC_CUSTOM0: begin
                rec_o.uop = UOP_THCTL; rec_o.rs1_re = 1'b1;
                if (f3 == 3'd0) begin
                    rec_o.thctl = TH_TSPAWN; we = 1'b1;
                end else begin
                    rec_o.thctl = TH_BARRIER; rec_o.rs2_re = 1'b1;
                end
                bad = (f3 > 3'd1);
            end
            default: bad = 1'b1;
        endcase
        rec_o.rd_we = we && (rec_o.rd != 5'd0);
        if (bad) begin
            rec_o.uop    = UOP_ALUI;
            rec_o.rd_we  = 1'b0;
            rec_o.rs1_re = 1'b0;
            rec_o.rs2_re = 1'b0;
            rec_o.imm    = '0;
            rec_o.thctl  = TH_NONE;
        end
        rec_o.illegal = bad;
    end
endmodule

// File: rtl/mrv1_idecode.sv
// Decode stage: combinational decode feeding a 2-entry elastic buffer
// (OUT drives issue, SKID absorbs one beat of backpressure) with per-thread kill.
module mrv1_idecode
    import mrv1_dec_pkg::*;
#(
    parameter int PC_WIDTH_P    = 32,
    parameter int NUM_THREADS_P = 8,
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    mrv1_idecode_if.slave           bus,
    input  logic                    exec_b_pc_vld_i,
    input  logic [TID_WIDTH_LP-1:0] exec_tid_i
);
    dec_rec_t                in_rec;
    dec_rec_t                out_rec_q, out_rec_d, skid_rec_q, skid_rec_d;
    logic [PC_WIDTH_P-1:0]   out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic [TID_WIDTH_LP-1:0] out_tid_q, out_tid_d, skid_tid_q, skid_tid_d;
    logic                    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic                    out_live, skid_live, in_live, deq, out_free;

    mrv1_dec_logic u_dec_logic (.insn_i(bus.ifetch_insn_data_i), .rec_o(in_rec));

    // flush is resolved first: killed entries simply look empty to the move logic
    assign out_live  = out_vld_q  && !(exec_b_pc_vld_i && out_tid_q  == exec_tid_i);
    assign skid_live = skid_vld_q && !(exec_b_pc_vld_i && skid_tid_q == exec_tid_i);
    assign in_live   = bus.ifetch_insn_vld_i && !skid_vld_q &&
                       !(exec_b_pc_vld_i && bus.ifetch_insn_tid_i == exec_tid_i);
    assign deq       = out_live && bus.dec_rdy_i;
    assign out_free  = !out_live || deq;

    always_comb begin
        out_rec_d  = out_rec_q;  out_pc_d  = out_pc_q;  out_tid_d  = out_tid_q;
        skid_rec_d = skid_rec_q; skid_pc_d = skid_pc_q; skid_tid_d = skid_tid_q;
        out_vld_d  = out_live;
        skid_vld_d = skid_live;
        if (out_free && skid_live) begin
            out_vld_d = 1'b1;
            out_rec_d = skid_rec_q; out_pc_d = skid_pc_q; out_tid_d = skid_tid_q;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            out_vld_d = in_live;
            out_rec_d = in_rec; out_pc_d = bus.ifetch_insn_pc_i; out_tid_d = bus.ifetch_insn_tid_i;
        end else if (in_live) begin
            skid_vld_d = 1'b1;
            skid_rec_d = in_rec; skid_pc_d = bus.ifetch_insn_pc_i; skid_tid_d = bus.ifetch_insn_tid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        out_rec_q  <= out_rec_d;  out_pc_q  <= out_pc_d;  out_tid_q  <= out_tid_d;
        skid_rec_q <= skid_rec_d; skid_pc_q <= skid_pc_d; skid_tid_q <= skid_tid_d;
    end

    assign bus.ifetch_insn_rdy_o = !skid_vld_q;
    assign bus.dec_vld_o         = out_live;
    assign bus.dec_pc_o          = out_pc_q;
    assign bus.dec_tid_o         = out_tid_q;
    assign bus.dec_uop_o         = out_rec_q.uop;
    assign bus.dec_funct3_o      = out_rec_q.funct3;
    assign bus.dec_alt_o         = out_rec_q.alt;
    assign bus.dec_rd_o          = out_rec_q.rd;
    assign bus.dec_rs1_o         = out_rec_q.rs1;
    assign bus.dec_rs2_o         = out_rec_q.rs2;
    assign bus.dec_rd_we_o       = out_rec_q.rd_we;
    assign bus.dec_rs1_re_o      = out_rec_q.rs1_re;
    assign bus.dec_rs2_re_o      = out_rec_q.rs2_re;
    assign bus.dec_imm_o         = out_rec_q.imm;
    assign bus.dec_thctl_o       = out_rec_q.thctl;
    assign bus.dec_illegal_o     = out_rec_q.illegal;
endmodule
